// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the fetch PC, issues req/ack fetches, buffers words for Decode.
// Optional perf counters when FETCH_PERF_EN is defined; redirects flush the prefetch queue the same edge.
module fetch_sequencer #(
    parameter int              BITS     = 32,
    parameter logic [BITS-1:0] RESET_PC = '0,
    parameter int              QDEPTH   = 2
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [BITS-1:0] ALUResultE,
    input  logic [BITS-1:0] ResultW,
    input  logic            BranchE,
    input  logic            PCSrcW,
    input  logic            StallF,
    output logic            imem_req,
    output logic [BITS-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [BITS-1:0] imem_rdata,
    output logic [BITS-1:0] InstrF,
    output logic [BITS-1:0] PCPlus4F,
    output logic            InstrValidF
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_redirects,
    output logic [31:0]     perf_bubbles
`endif
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_RUN, S_WAIT, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [BITS-1:0]   pc_q, pc_d;
    logic [BITS-1:0]   addr_q, addr_d;
    logic              req_q, req_d;
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d, count_after_pop;
    logic [BITS-1:0]   instr_mem_q [QDEPTH];
    logic [BITS-1:0]   pc4_mem_q   [QDEPTH];

    logic              redirect, pop, push;
    logic [BITS-1:0]   target, pc_plus4;

    always_comb begin
        redirect        = BranchE | PCSrcW;
        target          = BranchE ? ALUResultE : ResultW;
        pc_plus4        = pc_q + BITS'(4);
        pop             = (count_q != '0) && !StallF;
        count_after_pop = count_q - CW'(pop);
        push            = 1'b0;
        state_d         = state_q;
        pc_d            = pc_q;
        addr_d          = addr_q;

        case (state_q)
            S_RUN: begin
                if (redirect) begin
                    pc_d = target;
                end else if (count_after_pop < CW'(QDEPTH)) begin
                    state_d = S_WAIT;
                    addr_d  = pc_q;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = imem_ack ? S_RUN : S_DRAIN;
                end else if (imem_ack) begin
                    push    = 1'b1;
                    pc_d    = pc_plus4;
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                // The in-flight access cannot be cancelled; only the PC follows redirects.
                if (redirect) pc_d = target;
                if (imem_ack) state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase

        req_d = (state_d != S_RUN);

        if (redirect) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = pop  ? head_q + PW'(1) : head_q;
            tail_d  = push ? tail_q + PW'(1) : tail_q;
            count_d = count_after_pop + CW'(push);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            instr_mem_q[tail_q] <= imem_rdata;
            pc4_mem_q[tail_q]   <= pc_plus4;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign InstrValidF = (count_q != '0);
    assign InstrF      = InstrValidF ? instr_mem_q[head_q] : '0;
    assign PCPlus4F    = InstrValidF ? pc4_mem_q[head_q]   : '0;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_redirects_q, perf_redirects_d;
    logic [31:0] perf_bubbles_q, perf_bubbles_d;

    always_comb begin
        perf_redirects_d = perf_redirects_q;
        perf_bubbles_d   = perf_bubbles_q;
        if (redirect && perf_redirects_q != '1) perf_redirects_d = perf_redirects_q + 32'd1;
        if (!InstrValidF && perf_bubbles_q != '1) perf_bubbles_d = perf_bubbles_q + 32'd1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            perf_redirects_q <= '0;
            perf_bubbles_q   <= '0;
        end else begin
            perf_redirects_q <= perf_redirects_d;
            perf_bubbles_q   <= perf_bubbles_d;
        end
    end

    assign perf_redirects = perf_redirects_q;
    assign perf_bubbles   = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomised bench for fetch_sequencer: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fetch_sequencer;
    localparam int QDEPTH = 2;

    logic        CLK = 1'b0;
    logic        RESET, BranchE, PCSrcW, StallF, imem_ack;
    logic [31:0] ALUResultE, ResultW, imem_rdata;
    logic        imem_req, InstrValidF;
    logic [31:0] imem_addr, InstrF, PCPlus4F;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_redirects, perf_bubbles;
`endif

    always #5 CLK = ~CLK;

    fetch_sequencer #(.BITS(32), .RESET_PC(32'h0), .QDEPTH(QDEPTH)) dut (
        .CLK(CLK), .RESET(RESET), .ALUResultE(ALUResultE), .ResultW(ResultW),
        .BranchE(BranchE), .PCSrcW(PCSrcW), .StallF(StallF),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .InstrF(InstrF), .PCPlus4F(PCPlus4F), .InstrValidF(InstrValidF)
`ifdef FETCH_PERF_EN
        , .perf_redirects(perf_redirects), .perf_bubbles(perf_bubbles)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: mode 0 = idle, 1 = fetch in flight, 2 = fetch in flight but stale.
    int          m_mode;
    logic [31:0] m_pc, m_addr;
    logic [31:0] m_instr[$];
    logic [31:0] m_pc4[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic compare_model();
        chk("model_req", {31'd0, imem_req}, {31'd0, m_mode != 0});
        if (m_mode != 0) chk("model_addr", imem_addr, m_addr);
        chk("model_valid", {31'd0, InstrValidF}, {31'd0, m_instr.size() != 0});
        chk("model_instr", InstrF, (m_instr.size() != 0) ? m_instr[0] : 32'h0);
        chk("model_pc4", PCPlus4F, (m_pc4.size() != 0) ? m_pc4[0] : 32'h0);
    endtask

    task automatic model_step(input logic rst, br, pcs, stall, ack,
                              input logic [31:0] alu, resw, rdata);
        logic        redir;
        logic [31:0] tgt;
        redir = br | pcs;
        tgt   = br ? alu : resw;
        if (rst) begin
            m_pc = 32'h0; m_mode = 0; m_instr.delete(); m_pc4.delete();
            return;
        end
        if (m_instr.size() != 0 && !stall) begin
            void'(m_instr.pop_front());
            void'(m_pc4.pop_front());
        end
        if (redir) begin
            m_instr.delete(); m_pc4.delete();
            m_pc = tgt;
            if (m_mode == 1) m_mode = ack ? 0 : 2;
            else if (m_mode == 2 && ack) m_mode = 0;
        end else if (m_mode == 0) begin
            if (m_instr.size() < QDEPTH) begin
                m_mode = 1; m_addr = m_pc;
            end
        end else if (ack) begin
            if (m_mode == 1) begin
                m_instr.push_back(rdata);
                m_pc4.push_back(m_pc + 32'd4);
                m_pc = m_pc + 32'd4;
            end
            m_mode = 0;
        end
    endtask

    task automatic cycle(input logic rst, br, pcs, stall, ack,
                         input logic [31:0] alu, resw, rdata);
        RESET = rst; BranchE = br; PCSrcW = pcs; StallF = stall; imem_ack = ack;
        ALUResultE = alu; ResultW = resw; imem_rdata = rdata;
        model_step(rst, br, pcs, stall, ack, alu, resw, rdata);
        @(posedge CLK);
        @(negedge CLK);
        compare_model();
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic idle(input logic stall, input logic ack);
        cycle(1'b0, 1'b0, 1'b0, stall, ack, 32'h0, 32'h0, word_at(m_addr));
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] addrs[3];
        logic [31:0] pc4s[3];
        int na, np;
        RESET = 1'b1; BranchE = 1'b0; PCSrcW = 1'b0; StallF = 1'b0; imem_ack = 1'b0;
        ALUResultE = '0; ResultW = '0; imem_rdata = '0;
        m_mode = 0; m_pc = 0; m_addr = 0;
        @(negedge CLK);

        // Reset state
        do_reset();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, InstrValidF}, 32'd0);
        chk("rst_instr", InstrF, 32'h0);
        chk("rst_pc4", PCPlus4F, 32'h0);

        // Sequential fetch with ack on every request
        for (int i = 0; i < 3; i++) begin addrs[i] = 32'hDEADBEEF; pc4s[i] = 32'hDEADBEEF; end
        na = 0; np = 0;
        for (int i = 0; i < 8; i++) begin
            idle(1'b0, m_mode != 0);
            if (imem_req && na < 3) begin addrs[na] = imem_addr; na++; end
            if (InstrValidF && np < 3) begin pc4s[np] = PCPlus4F; np++; end
        end
        chk("seq_addr0", addrs[0], 32'h0);
        chk("seq_addr1", addrs[1], 32'h4);
        chk("seq_addr2", addrs[2], 32'h8);
        chk("seq_pc4_0", pc4s[0], 32'h4);
        chk("seq_pc4_1", pc4s[1], 32'h8);
        chk("seq_pc4_2", pc4s[2], 32'hC);

        // Stall fills exactly QDEPTH entries
        do_reset();
        for (int i = 0; i < 10; i++) idle(1'b1, m_mode != 0);
        chk("stall_req", {31'd0, imem_req}, 32'd0);
        chk("stall_valid", {31'd0, InstrValidF}, 32'd1);
        chk("stall_head_pc4", PCPlus4F, 32'h4);
        chk("stall_head_instr", InstrF, word_at(32'h0));
        idle(1'b0, 1'b0);
        chk("release_pc4", PCPlus4F, 32'h8);
        chk("release_req", {31'd0, imem_req}, 32'd1);
        chk("release_addr", imem_addr, 32'h8);
        idle(1'b0, 1'b0);
        chk("release_empty", {31'd0, InstrValidF}, 32'd0);

        // Branch while waiting: drain and drop the stale word
        do_reset();
        idle(1'b0, 1'b0);
        chk("drn_req0", imem_addr, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0);
        chk("drn_hold_req", {31'd0, imem_req}, 32'd1);
        chk("drn_hold_addr", imem_addr, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h1111_1111);
        chk("drn_dropped", {31'd0, InstrValidF}, 32'd0);
        idle(1'b0, 1'b0);
        chk("drn_new_addr", imem_addr, 32'h100);
        chk("drn_still_empty", {31'd0, InstrValidF}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'hCAFE_0100);
        chk("drn_instr", InstrF, 32'hCAFE_0100);
        chk("drn_pc4", PCPlus4F, 32'h104);

        // BranchE beats PCSrcW, queue flushed
        do_reset();
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b1);
        chk("both_pre_valid", {31'd0, InstrValidF}, 32'd1);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h300, 32'h0);
        chk("both_flushed", {31'd0, InstrValidF}, 32'd0);
        idle(1'b1, 1'b0);
        chk("both_addr", imem_addr, 32'h200);

        // PC wrap at the top of the address space
        do_reset();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0);
        idle(1'b1, 1'b0);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        idle(1'b1, 1'b1);
        chk("wrap_pc4", PCPlus4F, 32'h0);
        idle(1'b1, 1'b0);
        chk("wrap_next_addr", imem_addr, 32'h0);

        // Reset in the middle of a request
        do_reset();
        idle(1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        do_reset();
        chk("midrst_req", {31'd0, imem_req}, 32'd0);
        chk("midrst_valid", {31'd0, InstrValidF}, 32'd0);
        idle(1'b0, 1'b0);
        chk("midrst_addr", imem_addr, 32'h0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            logic r, b, p, s, a;
            logic [31:0] alu, resw;
            r = ($urandom_range(0, 199) == 0);
            b = ($urandom_range(0, 11) == 0);
            p = ($urandom_range(0, 11) == 0);
            s = ($urandom_range(0, 2) == 0);
            a = (m_mode != 0) && ($urandom_range(0, 1) == 0);
            alu  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : ($urandom & ~32'h3);
            resw = $urandom & ~32'h3;
            cycle(r, b, p, s, a, alu, resw, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
